// File: rtl/posit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : posit_pkg
// Description : Posit format definitions, operand-info flags, class-mask
//               bit indices and format helper functions.
// Revision    : 1.0
// ============================================================================
package posit_pkg;

    typedef enum logic [1:0] {
        POSIT8  = 2'd0,
        POSIT16 = 2'd1,
        POSIT32 = 2'd2
    } posit_format_e;

    typedef struct packed {
        logic is_zero;
        logic is_inf;
        logic is_NaR;
        logic is_pos;
        logic is_neg;
    } posit_info_t;

    typedef enum int unsigned {
        CLS_NAR       = 0,
        CLS_NEG_LARGE = 1,
        CLS_NEG_SMALL = 2,
        CLS_ZERO      = 3,
        CLS_POS_SMALL = 4,
        CLS_POS_LARGE = 5,
        CLS_MAXPOS    = 6,
        CLS_MINPOS    = 7
    } posit_class_e;

    localparam int unsigned POSIT_CLASS_BITS = 8;

    function automatic int unsigned posit_width(posit_format_e fmt);
        case (fmt)
            POSIT16: return 16;
            POSIT32: return 32;
            default: return 8;
        endcase
    endfunction

    // Returned zero-extended to 32 bits; callers truncate to their width.
    function automatic logic [31:0] maxpos(posit_format_e fmt);
        return (32'h1 << (posit_width(fmt) - 1)) - 32'h1;
    endfunction

    function automatic logic [31:0] minpos(posit_format_e fmt);
        if (posit_width(fmt) == 0) return 32'h0;
        return 32'h1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/posit_class_core.sv
`default_nettype none
// ============================================================================
// Module      : posit_class_core
// Description : Combinational classification of a single posit operand into
//               info flags and an 8-bit class mask.
// Revision    : 1.0
// ============================================================================
module posit_class_core
    import posit_pkg::*;
#(
    parameter posit_format_e pFormat = posit_format_e'(0)
) (
    input  logic [posit_width(pFormat)-1:0] operand_i,
    output posit_info_t                     info_o,
    output logic [POSIT_CLASS_BITS-1:0]     class_o
);

    localparam int unsigned          WIDTH    = posit_width(pFormat);
    localparam logic [WIDTH-1:0]     c_maxpos = WIDTH'(maxpos(pFormat));
    localparam logic [WIDTH-1:0]     c_minpos = WIDTH'(minpos(pFormat));
    localparam logic [WIDTH-1:0]     c_nar    = {1'b1, {(WIDTH-1){1'b0}}};

    logic             w_zero;
    logic             w_nar;
    logic             w_pos;
    logic             w_neg;
    logic             w_large;
    logic [WIDTH-1:0] w_mag;

    always_comb begin
        w_zero  = (operand_i == '0);
        w_nar   = (operand_i == c_nar);
        w_pos   = ~operand_i[WIDTH-1] & ~w_zero;
        w_neg   = operand_i[WIDTH-1] & ~w_nar;
        w_mag   = w_neg ? (~operand_i + c_minpos) : operand_i;
        // Regime bit right below the sign decides |x| >= 1.
        w_large = w_mag[WIDTH-2];

        info_o.is_zero = w_zero;
        info_o.is_inf  = w_nar;
        info_o.is_NaR  = w_nar;
        info_o.is_pos  = w_pos;
        info_o.is_neg  = w_neg;

        class_o                = '0;
        class_o[CLS_NAR]       = w_nar;
        class_o[CLS_NEG_LARGE] = w_neg & w_large;
        class_o[CLS_NEG_SMALL] = w_neg & ~w_large;
        class_o[CLS_ZERO]      = w_zero;
        class_o[CLS_POS_SMALL] = w_pos & ~w_large;
        class_o[CLS_POS_LARGE] = w_pos & w_large;
        class_o[CLS_MAXPOS]    = (w_pos | w_neg) & (w_mag == c_maxpos);
        class_o[CLS_MINPOS]    = (w_pos | w_neg) & (w_mag == c_minpos);
    end

endmodule
`default_nettype wire

// File: rtl/posit_classifier_pipe.sv
`default_nettype none
// ============================================================================
// Module      : posit_classifier_pipe
// Description : Multi-operand posit classifier with valid/ready handshake,
//               configurable pipeline depth and opaque tag passthrough.
// Revision    : 1.0
// ============================================================================
module posit_classifier_pipe
    import posit_pkg::*;
#(
    parameter posit_format_e pFormat     = posit_format_e'(0),
    parameter int unsigned   NumOperands = 3,
    parameter int unsigned   NumPipeRegs = 1,
    parameter int unsigned   TagWidth    = 4
) (
    input  logic                                                clk_i,
    input  logic                                                rst_i,
    input  logic                                                flush_i,
    input  logic                                                in_valid_i,
    output logic                                                in_ready_o,
    input  logic [NumOperands-1:0][posit_width(pFormat)-1:0]    operands_i,
    input  logic [TagWidth-1:0]                                 tag_i,
    output logic                                                out_valid_o,
    input  logic                                                out_ready_i,
    output posit_info_t [NumOperands-1:0]                       info_o,
    output logic [NumOperands-1:0][POSIT_CLASS_BITS-1:0]        class_o,
    output logic [TagWidth-1:0]                                 tag_o,
    output logic                                                busy_o
);

    posit_info_t [NumOperands-1:0]                w_info;
    logic [NumOperands-1:0][POSIT_CLASS_BITS-1:0] w_class;

    for (genvar gi = 0; gi < NumOperands; gi++) begin : g_core
        posit_class_core #(
            .pFormat (pFormat)
        ) u_core (
            .operand_i (operands_i[gi]),
            .info_o    (w_info[gi]),
            .class_o   (w_class[gi])
        );
    end

    if (NumPipeRegs == 0) begin : g_comb
        assign out_valid_o = in_valid_i;
        assign in_ready_o  = out_ready_i;
        assign busy_o      = 1'b0;
        assign info_o      = in_valid_i ? w_info  : '0;
        assign class_o     = in_valid_i ? w_class : '0;
        assign tag_o       = in_valid_i ? tag_i   : '0;
    end else begin : g_pipe
        localparam int unsigned c_last = NumPipeRegs - 1;

        logic [NumPipeRegs-1:0] r_valid;
        logic [NumPipeRegs:0]   w_ready;
        logic [NumPipeRegs-1:0] w_up_valid;

        posit_info_t [NumOperands-1:0]                r_info    [NumPipeRegs];
        logic [NumOperands-1:0][POSIT_CLASS_BITS-1:0] r_class   [NumPipeRegs];
        logic [TagWidth-1:0]                          r_tag     [NumPipeRegs];
        posit_info_t [NumOperands-1:0]                w_in_info [NumPipeRegs];
        logic [NumOperands-1:0][POSIT_CLASS_BITS-1:0] w_in_class[NumPipeRegs];
        logic [TagWidth-1:0]                          w_in_tag  [NumPipeRegs];

        // Ready ripples backwards: a stage can take a beat if it is empty or
        // its occupant moves on in the same cycle.
        always_comb begin
            w_ready[NumPipeRegs] = out_ready_i;
            for (int k = NumPipeRegs - 1; k >= 0; k--) begin
                w_ready[k] = ~r_valid[k] | w_ready[k+1];
            end
        end

        always_comb begin
            w_up_valid[0] = in_valid_i;
            w_in_info[0]  = w_info;
            w_in_class[0] = w_class;
            w_in_tag[0]   = tag_i;
            for (int k = 1; k < NumPipeRegs; k++) begin
                w_up_valid[k] = r_valid[k-1];
                w_in_info[k]  = r_info[k-1];
                w_in_class[k] = r_class[k-1];
                w_in_tag[k]   = r_tag[k-1];
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i || flush_i) begin
                r_valid <= '0;
            end else begin
                for (int k = 0; k < NumPipeRegs; k++) begin
                    if (w_ready[k]) r_valid[k] <= w_up_valid[k];
                end
            end
        end

        // Payload is qualified by r_valid, so it needs no reset.
        always_ff @(posedge clk_i) begin
            for (int k = 0; k < NumPipeRegs; k++) begin
                if (w_ready[k] && w_up_valid[k]) begin
                    r_info[k]  <= w_in_info[k];
                    r_class[k] <= w_in_class[k];
                    r_tag[k]   <= w_in_tag[k];
                end
            end
        end

        assign in_ready_o  = w_ready[0];
        assign out_valid_o = r_valid[c_last];
        assign busy_o      = |r_valid;
        assign info_o      = r_valid[c_last] ? r_info[c_last]  : '0;
        assign class_o     = r_valid[c_last] ? r_class[c_last] : '0;
        assign tag_o       = r_valid[c_last] ? r_tag[c_last]   : '0;
    end

endmodule
`default_nettype wire

// File: tb/tb_posit_classifier_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_posit_classifier_pipe
// Description : Randomized self-checking bench for posit_classifier_pipe
//               (posit8, 3 operands, 2-stage and 0-stage builds).
// Revision    : 1.0
// ============================================================================
module tb_posit_classifier_pipe;
    import posit_pkg::*;

    localparam int c_lat = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic                flush;
    logic                in_valid;
    logic [2:0][7:0]     operands;
    logic [3:0]          tag;
    logic                out_ready;

    logic                in_ready2, out_valid2, busy2;
    posit_info_t [2:0]   info2;
    logic [2:0][7:0]     class2;
    logic [3:0]          tag2;

    logic                in_ready0, out_valid0, busy0;
    posit_info_t [2:0]   info0;
    logic [2:0][7:0]     class0;
    logic [3:0]          tag0;

    always #5 clk = ~clk;

    posit_classifier_pipe #(
        .pFormat (POSIT8), .NumOperands (3), .NumPipeRegs (2), .TagWidth (4)
    ) u_dut2 (
        .clk_i (clk), .rst_i (rst), .flush_i (flush),
        .in_valid_i (in_valid), .in_ready_o (in_ready2),
        .operands_i (operands), .tag_i (tag),
        .out_valid_o (out_valid2), .out_ready_i (out_ready),
        .info_o (info2), .class_o (class2), .tag_o (tag2), .busy_o (busy2)
    );

    posit_classifier_pipe #(
        .pFormat (POSIT8), .NumOperands (3), .NumPipeRegs (0), .TagWidth (4)
    ) u_dut0 (
        .clk_i (clk), .rst_i (rst), .flush_i (flush),
        .in_valid_i (in_valid), .in_ready_o (in_ready0),
        .operands_i (operands), .tag_i (tag),
        .out_valid_o (out_valid0), .out_ready_i (out_ready),
        .info_o (info0), .class_o (class0), .tag_o (tag0), .busy_o (busy0)
    );

    typedef struct {
        logic [2:0][7:0] ops;
        logic [3:0]      tag;
        int              acc;
    } beat_t;

    beat_t sb[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    int    cyc      = 0;

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference: interpret the posit as a two's-complement integer.
    function automatic posit_info_t ref_info(input logic [7:0] x);
        posit_info_t r;
        int s;
        s = int'($signed(x));
        r.is_zero = (x == 8'h00);
        r.is_NaR  = (x == 8'h80);
        r.is_inf  = r.is_NaR;
        r.is_pos  = (s > 0);
        r.is_neg  = (s < 0) && !r.is_NaR;
        return r;
    endfunction

    function automatic logic [7:0] ref_class(input logic [7:0] x);
        posit_info_t f;
        int mag;
        logic [7:0] c;
        f   = ref_info(x);
        mag = int'($signed(x));
        if (mag < 0) mag = -mag;
        c = 8'h00;
        if (f.is_NaR)  c = 8'h01;
        else if (f.is_zero) c = 8'h08;
        else if (f.is_neg) c = (mag >= 64) ? 8'h02 : 8'h04;
        else           c = (mag >= 64) ? 8'h20 : 8'h10;
        if ((f.is_pos || f.is_neg) && mag == 127) c = c | 8'h40;
        if ((f.is_pos || f.is_neg) && mag == 1)   c = c | 8'h80;
        return c;
    endfunction

    function automatic logic [23:0] ref_class3(input logic [2:0][7:0] ops);
        logic [23:0] r;
        for (int i = 0; i < 3; i++) r[i*8 +: 8] = ref_class(ops[i]);
        return r;
    endfunction

    function automatic logic [14:0] ref_info3(input logic [2:0][7:0] ops);
        logic [14:0] r;
        for (int i = 0; i < 3; i++) r[i*5 +: 5] = ref_info(ops[i]);
        return r;
    endfunction

    task automatic step(input logic v, input logic [2:0][7:0] ops, input logic [3:0] tg,
                        input logic ordy, input logic r, input logic f);
        logic exp_rdy, exp_ov;
        beat_t b;
        in_valid = v; operands = ops; tag = tg; out_ready = ordy; rst = r; flush = f;
        #1;
        exp_rdy = (sb.size() < c_lat) || ordy;
        exp_ov  = (sb.size() > 0) && ((cyc - sb[0].acc) >= c_lat);
        check_eq("in_ready", {31'd0, in_ready2}, {31'd0, exp_rdy});
        check_eq("out_valid", {31'd0, out_valid2}, {31'd0, exp_ov});
        check_eq("busy", {31'd0, busy2}, {31'd0, sb.size() > 0});
        if (out_valid2) begin
            if (sb.size() == 0) begin
                check_eq("stale_beat", {31'd0, out_valid2}, 32'd0);
            end else begin
                check_eq("class", {8'd0, class2}, {8'd0, ref_class3(sb[0].ops)});
                check_eq("info", {17'd0, info2}, {17'd0, ref_info3(sb[0].ops)});
                check_eq("tag", {28'd0, tag2}, {28'd0, sb[0].tag});
                if (ordy) void'(sb.pop_front());
            end
        end else begin
            check_eq("gated_out", {1'b0, class2, tag2, info2}, 32'd0);
        end
        check_eq("p0_valid", {31'd0, out_valid0}, {31'd0, v});
        check_eq("p0_ready", {31'd0, in_ready0}, {31'd0, ordy});
        check_eq("p0_busy", {31'd0, busy0}, 32'd0);
        check_eq("p0_class", {8'd0, class0}, v ? {8'd0, ref_class3(ops)} : 32'd0);
        check_eq("p0_info_tag", {13'd0, info0, tag0}, v ? {13'd0, ref_info3(ops), tg} : 32'd0);
        if (r || f) begin
            sb.delete();
        end else if (v && exp_rdy) begin
            b.ops = ops; b.tag = tg; b.acc = cyc;
            sb.push_back(b);
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    function automatic logic [7:0] rand_op();
        case ($urandom_range(0, 7))
            0: return 8'h00;
            1: return 8'h80;
            2: return 8'h7F;
            3: return 8'h81;
            4: return 8'h01;
            5: return 8'hFF;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        logic [2:0][7:0] ro;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; operands = '0; tag = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("rst_out_valid", {31'd0, out_valid2}, 32'd0);
        check_eq("rst_busy", {31'd0, busy2}, 32'd0);
        check_eq("rst_in_ready", {31'd0, in_ready2}, 32'd1);
        @(negedge clk);

        // Directed classification beats (operand 0 is the low element).
        step(1'b1, {8'h40, 8'h80, 8'h00}, 4'h5, 1'b1, 1'b0, 1'b0);
        step(1'b1, {8'hE0, 8'hC0, 8'h20}, 4'h6, 1'b1, 1'b0, 1'b0);
        step(1'b1, {8'h81, 8'h01, 8'h7F}, 4'h7, 1'b1, 1'b0, 1'b0);
        step(1'b1, {8'hFF, 8'hFF, 8'hFF}, 4'h8, 1'b1, 1'b0, 1'b0);
        repeat (3) step(1'b0, '0, 4'h0, 1'b1, 1'b0, 1'b0);
        check_eq("dir_class_first", {8'd0, ref_class3({8'h40, 8'h80, 8'h00})}, 32'h0020_0108);

        // Back-pressure: four stalled cycles with continuous offers.
        for (int i = 0; i < 4; i++)
            step(1'b1, {rand_op(), rand_op(), rand_op()}, 4'(i + 9), 1'b0, 1'b0, 1'b0);
        repeat (4) step(1'b0, '0, 4'h0, 1'b1, 1'b0, 1'b0);

        // Reset, then flush, with two beats in flight.
        for (int pass = 0; pass < 2; pass++) begin
            step(1'b1, {8'h11, 8'h22, 8'h33}, 4'hA, 1'b1, 1'b0, 1'b0);
            step(1'b1, {8'h44, 8'h55, 8'h66}, 4'hB, 1'b1, 1'b0, 1'b0);
            step(1'b1, {8'h77, 8'h88, 8'h99}, 4'hC, 1'b0, pass == 0, pass == 1);
            check_eq("post_drop_valid", {31'd0, out_valid2}, 32'd0);
            check_eq("post_drop_busy", {31'd0, busy2}, 32'd0);
            repeat (3) step(1'b0, '0, 4'h0, 1'b1, 1'b0, 1'b0);
        end

        // Randomized traffic with occasional flush and reset.
        for (int i = 0; i < 400; i++) begin
            ro = {rand_op(), rand_op(), rand_op()};
            step($urandom_range(0, 3) != 0, ro, 4'($urandom), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 60) == 0, $urandom_range(0, 40) == 0);
        end
        repeat (4) step(1'b0, '0, 4'h0, 1'b1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
